// File: rtl/sd_card_dat.sv
// sd_card_dat: card-side DAT0 endpoint that receives write blocks with CRC status token and busy, and sends read blocks with CRC16
module sd_card_dat #(
  parameter int BLOCK_WORDS = 128,
  parameter int BUSY_CYCLES = 8,
  parameter int NAC = 2
) (
  input  logic        SDclock,
  input  logic        reset,
  input  logic        dat_in,
  output logic        dat_out,
  output logic        dat_oe,
  input  logic        write_en,
  input  logic        read_req,
  input  logic [31:0] rd_word,
  output logic        rd_pop,
  output logic [31:0] wr_word,
  output logic        wr_valid,
  output logic        crc_ok,
  output logic        busy,
  output logic        done
);
  localparam int NBITS = 32 * BLOCK_WORDS;
  localparam int CW = $clog2(NBITS) + 1;
  typedef enum logic [3:0] {
    IDLE, RX_DATA, RX_CRC, RX_END, TOK_TURN, TOK, WR_BUSY,
    RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] sh;
  logic [15:0] crc;
  logic [3:0] tsh;
  logic ok;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  assign busy = state != IDLE;
  assign ok = (sh[15:0] == crc) && dat_in;
  always_ff @(posedge SDclock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      crc <= '0;
      tsh <= '0;
      dat_out <= 1'b1;
      dat_oe <= 1'b0;
      rd_pop <= 1'b0;
      wr_word <= '0;
      wr_valid <= 1'b0;
      crc_ok <= 1'b1;
      done <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          dat_oe <= 1'b0;
          dat_out <= 1'b1;
          cnt <= '0;
          crc <= '0;
          state <= read_req ? RD_WAIT : (write_en && !dat_in) ? RX_DATA : IDLE;
        end
        RX_DATA: begin
          sh <= {sh[30:0], dat_in};
          crc <= crc_step(crc, dat_in);
          cnt <= cnt + 1'b1;
          if (cnt[4:0] == 5'd31) begin
            wr_word <= {sh[30:0], dat_in};
            wr_valid <= 1'b1;
          end
          if (cnt == CW'(NBITS - 1)) begin
            cnt <= '0;
            state <= RX_CRC;
          end
        end
        RX_CRC: begin
          sh <= {sh[30:0], dat_in};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(15)) begin
            cnt <= '0;
            state <= RX_END;
          end
        end
        RX_END: begin
          crc_ok <= ok;
          tsh <= ok ? 4'b0101 : 4'b1011;
          state <= TOK_TURN;
        end
        TOK_TURN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(1)) begin
            cnt <= '0;
            state <= TOK;
            dat_oe <= 1'b1;
            dat_out <= 1'b0;
          end
        end
        TOK: begin
          if (cnt == CW'(4)) begin
            cnt <= '0;
            state <= crc_ok ? WR_BUSY : IDLE;
            done <= !crc_ok;
            dat_oe <= crc_ok;
            dat_out <= !crc_ok;
          end else begin
            cnt <= cnt + 1'b1;
            dat_out <= tsh[3];
            tsh <= {tsh[2:0], 1'b0};
          end
        end
        WR_BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BUSY_CYCLES - 1)) begin
            cnt <= '0;
            state <= IDLE;
            done <= 1'b1;
            dat_oe <= 1'b0;
            dat_out <= 1'b1;
          end
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NAC - 1)) begin
            cnt <= '0;
            state <= RD_START;
            dat_oe <= 1'b1;
            dat_out <= 1'b0;
            rd_pop <= 1'b1;
          end
        end
        RD_START: begin
          sh <= rd_word;
          dat_out <= rd_word[31];
          crc <= crc_step(crc, rd_word[31]);
          rd_pop <= 1'b0;
          state <= RD_DATA;
        end
        RD_DATA: begin
          cnt <= cnt + 1'b1;
          rd_pop <= cnt[4:0] == 5'd30 && cnt < CW'(NBITS - 32);
          if (cnt == CW'(NBITS - 1)) begin
            cnt <= '0;
            state <= RD_CRC;
            dat_out <= crc[15];
            crc <= {crc[14:0], 1'b0};
          end else if (cnt[4:0] == 5'd31) begin
            sh <= rd_word;
            dat_out <= rd_word[31];
            crc <= crc_step(crc, rd_word[31]);
          end else begin
            sh <= {sh[30:0], 1'b0};
            dat_out <= sh[30];
            crc <= crc_step(crc, sh[30]);
          end
        end
        RD_CRC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(15)) begin
            cnt <= '0;
            state <= RD_END;
            dat_out <= 1'b1;
          end else begin
            dat_out <= crc[15];
            crc <= {crc[14:0], 1'b0};
          end
        end
        RD_END: begin
          state <= IDLE;
          done <= 1'b1;
          dat_oe <= 1'b0;
          dat_out <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_card_dat.sv
// tb_sd_card_dat: randomized bench for sd_card_dat against a polynomial-division CRC and line-level reference model
module tb_sd_card_dat;
  localparam int BW = 2;
  localparam int BC = 8;
  localparam int NC = 2;
  logic SDclock = 0, reset = 1, dat_in = 1, write_en = 0, read_req = 0;
  logic [31:0] rd_word = 0;
  logic dat_out, dat_oe, rd_pop, wr_valid, crc_ok, busy, done;
  logic [31:0] wr_word;
  int n_cmp = 0, n_bad = 0;
  typedef logic [31:0] blk_t [BW];

  sd_card_dat #(.BLOCK_WORDS(BW), .BUSY_CYCLES(BC), .NAC(NC)) dut (
    .SDclock(SDclock), .reset(reset), .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
    .write_en(write_en), .read_req(read_req), .rd_word(rd_word), .rd_pop(rd_pop),
    .wr_word(wr_word), .wr_valid(wr_valid), .crc_ok(crc_ok), .busy(busy), .done(done)
  );

  always #5 SDclock = ~SDclock;

  // remainder of message * x^16 divided by the generator polynomial
  function automatic logic [15:0] ref_crc(input blk_t w);
    logic [32*BW+15:0] m;
    m = {w[0], w[1], 16'h0000};
    for (int i = 32*BW+15; i >= 16; i--)
      if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
    return m[15:0];
  endfunction

  task automatic test_reset;
    reset = 1;
    @(negedge SDclock);
    @(negedge SDclock);
    n_cmp++; if (dat_out !== 1'b1) begin n_bad++; $display("FAIL reset dat_out got %b want 1", dat_out); end
    n_cmp++; if (dat_oe !== 1'b0) begin n_bad++; $display("FAIL reset dat_oe got %b want 0", dat_oe); end
    n_cmp++; if (rd_pop !== 1'b0) begin n_bad++; $display("FAIL reset rd_pop got %b want 0", rd_pop); end
    n_cmp++; if (wr_word !== 32'h0) begin n_bad++; $display("FAIL reset wr_word got %h want 0", wr_word); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset wr_valid got %b want 0", wr_valid); end
    n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL reset crc_ok got %b want 1", crc_ok); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b want 0", done); end
    reset = 0;
  endtask

  task automatic test_write(input blk_t w, input bit flip, input bit endb, input int abort_at, input string nm);
    bit q[$];
    int vpos[$];
    logic [31:0] vw[$];
    logic [15:0] c;
    logic [3:0] obs, exp;
    logic [4:0] tok;
    bit acc, eoe, eout;
    int oe_err, n;
    c = ref_crc(w);
    acc = !flip && endb;
    tok = acc ? 5'b00101 : 5'b01011;
    n = 7 + (acc ? BC : 0);
    oe_err = 0;
    q.push_back(1'b0);
    for (int i = 0; i < BW; i++)
      for (int b = 31; b >= 0; b--) q.push_back(w[i][b]);
    for (int b = 15; b >= 0; b--) q.push_back(c[b] ^ (flip && b == 7));
    q.push_back(endb);
    write_en = 1;
    foreach (q[p]) begin
      @(negedge SDclock);
      if (wr_valid) begin vpos.push_back(p); vw.push_back(wr_word); end
      if (dat_oe) oe_err++;
      dat_in = q[p];
    end
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge SDclock);
      if (k == 0) begin dat_in = 1; write_en = 0; end
      eoe = k >= 2 && k < n;
      eout = !eoe ? 1'b1 : (k < 7) ? tok[6-k] : 1'b0;
      exp = {eoe, eout, k == n, k < n};
      obs = {dat_oe, dat_oe ? dat_out : 1'b1, done, busy};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL %s line k=%0d {oe,out,done,busy} got %b want %b", nm, k, obs, exp); end
      if (k == abort_at) begin
        #2 reset = 1;
        #1;
        n_cmp++; if (dat_oe !== 1'b0) begin n_bad++; $display("FAIL %s async dat_oe got %b want 0", nm, dat_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s async busy got %b want 0", nm, busy); end
        @(negedge SDclock);
        reset = 0;
        return;
      end
    end
    n_cmp++; if (crc_ok !== acc) begin n_bad++; $display("FAIL %s crc_ok got %b want %b", nm, crc_ok, acc); end
    n_cmp++; if (oe_err !== 0) begin n_bad++; $display("FAIL %s oe during rx got %0d want 0", nm, oe_err); end
    n_cmp++;
    if (vw.size() !== BW) begin
      n_bad++; $display("FAIL %s wr_valid count got %0d want %0d", nm, vw.size(), BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        n_cmp++;
        if (vw[i] !== w[i] || vpos[i] !== 32*i + 33) begin
          n_bad++; $display("FAIL %s word%0d got %h@%0d want %h@%0d", nm, i, vw[i], vpos[i], w[i], 32*i + 33);
        end
      end
    end
  endtask

  task automatic test_read(input blk_t w, input bit with_wr, input int abort_at, input string nm);
    logic [15:0] c;
    logic [32*BW-1:0] d;
    logic [3:0] obs, exp;
    bit eoe, eout;
    int pops, nwv, last;
    c = ref_crc(w);
    d = {w[0], w[1]};
    pops = 0;
    nwv = 0;
    last = 3 + 32*BW + 16;
    @(negedge SDclock);
    read_req = 1;
    if (with_wr) begin write_en = 1; dat_in = 0; end
    for (int s = 0; s <= last + 2; s++) begin
      @(negedge SDclock);
      if (s == 0) begin read_req = 0; write_en = 0; dat_in = 1; end
      eoe = s >= 2 && s <= last;
      eout = !eoe ? 1'b1 : (s == 2) ? 1'b0 : (s < 3 + 32*BW) ? d[32*BW-1-(s-3)] :
             (s < last) ? c[15-(s-3-32*BW)] : 1'b1;
      exp = {eoe, eout, s == last + 1, s <= last};
      obs = {dat_oe, dat_oe ? dat_out : 1'b1, done, busy};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL %s line s=%0d {oe,out,done,busy} got %b want %b", nm, s, obs, exp); end
      if (wr_valid) nwv++;
      if (rd_pop) begin
        pops++;
        rd_word = (pops <= BW) ? w[pops-1] : $urandom;
      end
      if (s == abort_at) begin
        #2 reset = 1;
        #1;
        n_cmp++; if (dat_oe !== 1'b0) begin n_bad++; $display("FAIL %s async dat_oe got %b want 0", nm, dat_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s async busy got %b want 0", nm, busy); end
        @(negedge SDclock);
        reset = 0;
        return;
      end
    end
    n_cmp++; if (pops !== BW) begin n_bad++; $display("FAIL %s rd_pop count got %0d want %0d", nm, pops, BW); end
    n_cmp++; if (nwv !== 0) begin n_bad++; $display("FAIL %s wr_valid count got %0d want 0", nm, nwv); end
  endtask

  task automatic test_idle_noise;
    write_en = 0;
    dat_in = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge SDclock);
      n_cmp++;
      if ({dat_oe, busy} !== 2'b00) begin n_bad++; $display("FAIL idle_noise cyc%0d {oe,busy} got %b want 00", i, {dat_oe, busy}); end
    end
    dat_in = 1;
    @(negedge SDclock);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_noise after busy got %b want 0", busy); end
  endtask

  initial begin
    blk_t a, r;
    a[0] = 32'hDEADBEEF;
    a[1] = 32'h12345678;
    test_reset;
    test_write(a, 0, 1, -1, "wr_ok");
    test_write(a, 1, 1, -1, "wr_badcrc");
    test_write(a, 0, 0, -1, "wr_badend");
    test_read(a, 0, -1, "rd");
    test_read(a, 1, -1, "rd_vs_wr");
    test_idle_noise;
    r[0] = $urandom; r[1] = $urandom;
    test_read(r, 0, 20, "rd_rst");
    test_read(a, 0, -1, "rd_after_rdrst");
    test_write(a, 0, 1, 10, "wr_rst");
    r[0] = $urandom; r[1] = $urandom;
    test_read(r, 0, -1, "rd_after_wrrst");
    for (int i = 0; i < 4; i++) begin
      r[0] = $urandom; r[1] = $urandom;
      test_write(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, "wr_rand");
      r[0] = $urandom; r[1] = $urandom;
      test_read(r, 0, -1, "rd_rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
